// File: rtl/mips_pkg.sv
// Shared branch-unit definitions: branch type codes, FSM states, defaults, helpers.
package mips_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned XLEN          = 32;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BGEZ = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_RSV6 = 3'd6,
        BR_RSV7 = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } br_state_e;

    // True when every operand the branch type depends on is valid; reserved types need none.
    function automatic logic ops_ready(input logic [2:0] t, input logic rs_rdy, input logic rt_rdy);
        logic r;
        case (t)
            BR_BEQ, BR_BNE:                     r = rs_rdy & rt_rdy;
            BR_BGEZ, BR_BLEZ, BR_BGTZ, BR_BLTZ: r = rs_rdy;
            default:                            r = 1'b1;
        endcase
        return r;
    endfunction

    // pc + 4 + sign-extended word offset, wrapping mod 2^32.
    function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] pc, input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/br_cmp.sv
// Branch condition evaluator; purely combinational, signed zero tests on rs.
module br_cmp
    import mips_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  br_type,
    output logic        taken
);

    // Decode branch type into a taken decision; reserved types never take.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = (rs == rt);
            BR_BNE:  taken = (rs != rt);
            BR_BGEZ: taken = ($signed(rs) >= 32'sd0);
            BR_BLEZ: taken = ($signed(rs) <= 32'sd0);
            BR_BGTZ: taken = ($signed(rs) >  32'sd0);
            BR_BLTZ: taken = ($signed(rs) <  32'sd0);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller with operand wait, flush and saturating statistics.
module branch_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [31:0]      pc_id,
    input  logic [15:0]      imm16,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_rdy,
    input  logic             rt_rdy,
    output logic             stall,
    output logic             br_ack,
    output logic             redirect,
    output logic [31:0]      target,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e        state, state_nx;
    logic [2:0]       type_q, type_nx;
    logic [31:0]      pc_q, pc_nx;
    logic [15:0]      imm_q, imm_nx;
    logic             ack_nx, redir_nx;
    logic [31:0]      tgt_nx;
    logic [CNT_W-1:0] br_cnt_nx, taken_cnt_nx;
    logic             resolve;

    logic             in_idle;
    logic [2:0]       cmp_type;
    logic [31:0]      cmp_pc;
    logic [15:0]      cmp_imm;
    logic             cmp_taken;
    logic             ready;

    // In IDLE the branch is evaluated straight from the ID inputs; later from the latched copy.
    assign in_idle  = (state == IDLE);
    assign cmp_type = in_idle ? br_type : type_q;
    assign cmp_pc   = in_idle ? pc_id   : pc_q;
    assign cmp_imm  = in_idle ? imm16   : imm_q;
    assign ready    = ops_ready(cmp_type, rs_rdy, rt_rdy);

    // Freeze IF/ID for every cycle a branch is present except the acknowledge cycle.
    assign stall = br_valid & (state != RESOLVE);

    br_cmp u_cmp (
        .rs      (rs_val),
        .rt      (rt_val),
        .br_type (cmp_type),
        .taken   (cmp_taken)
    );

    // Next state, latched branch fields, registered result and counter updates.
    always_comb begin
        state_nx     = state;
        type_nx      = type_q;
        pc_nx        = pc_q;
        imm_nx       = imm_q;
        ack_nx       = 1'b0;
        redir_nx     = 1'b0;
        tgt_nx       = '0;
        br_cnt_nx    = br_cnt;
        taken_cnt_nx = taken_cnt;
        resolve      = 1'b0;

        case (state)
            IDLE: begin
                if (br_valid) begin
                    type_nx = br_type;
                    pc_nx   = pc_id;
                    imm_nx  = imm16;
                    if (ready) resolve = 1'b1;
                    else       state_nx = WAIT;
                end
            end
            WAIT: begin
                if (ready) resolve = 1'b1;
            end
            RESOLVE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (resolve) begin
            state_nx = RESOLVE;
            ack_nx   = 1'b1;
            redir_nx = cmp_taken;
            tgt_nx   = cmp_taken ? br_target(cmp_pc, cmp_imm) : 32'd0;
            if (br_cnt != {CNT_W{1'b1}}) br_cnt_nx = br_cnt + CNT_W'(1);
            if (cmp_taken && (taken_cnt != {CNT_W{1'b1}})) taken_cnt_nx = taken_cnt + CNT_W'(1);
        end

        // Flush abandons the branch and cancels anything it would launch this edge.
        if (flush) begin
            state_nx     = IDLE;
            ack_nx       = 1'b0;
            redir_nx     = 1'b0;
            tgt_nx       = '0;
            br_cnt_nx    = br_cnt;
            taken_cnt_nx = taken_cnt;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            type_q    <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            br_ack    <= 1'b0;
            redirect  <= 1'b0;
            target    <= '0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            state     <= state_nx;
            type_q    <= type_nx;
            pc_q      <= pc_nx;
            imm_q     <= imm_nx;
            br_ack    <= ack_nx;
            redirect  <= redir_nx;
            target    <= tgt_nx;
            br_cnt    <= br_cnt_nx;
            taken_cnt <= taken_cnt_nx;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized transaction-level bench for branch_ctrl against a behavioural branch model.
module tb_branch_ctrl;

    localparam int unsigned TB_CNT_W = 8;
    localparam int MAXC = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                flush;
    logic                br_valid;
    logic [2:0]          br_type;
    logic [31:0]         pc_id;
    logic [15:0]         imm16;
    logic [31:0]         rs_val, rt_val;
    logic                rs_rdy, rt_rdy;
    logic                stall, br_ack, redirect;
    logic [31:0]         target;
    logic [TB_CNT_W-1:0] br_cnt, taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_br     = 0;
    int m_tk     = 0;

    branch_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .br_valid  (br_valid),
        .br_type   (br_type),
        .pc_id     (pc_id),
        .imm16     (imm16),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .rs_rdy    (rs_rdy),
        .rt_rdy    (rt_rdy),
        .stall     (stall),
        .br_ack    (br_ack),
        .redirect  (redirect),
        .target    (target),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural branch outcome from the instruction-set definition.
    function automatic bit ref_taken(input int t, input logic [31:0] rs, input logic [31:0] rt);
        int signed s;
        s = $signed(rs);
        case (t)
            0: return rs == rt;
            1: return rs != rt;
            2: return s >= 0;
            3: return s <= 0;
            4: return s > 0;
            5: return s < 0;
            default: return 0;
        endcase
    endfunction

    // Cycle (relative to acceptance) at which all operands the branch needs are valid.
    function automatic int ref_need(input int t, input int drs, input int drt);
        if (t <= 1) return (drs > drt) ? drs : drt;
        if (t <= 5) return drs;
        return 0;
    endfunction

    task automatic check_cnts(input string tag);
        check({tag, "_br_cnt"},    32'(br_cnt),    32'(m_br));
        check({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(m_tk));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; br_valid = 1'b0; flush = 1'b0;
        rs_rdy = 1'b0; rt_rdy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_br = 0; m_tk = 0;
        check("rst_ack",   32'(br_ack),   32'd0);
        check("rst_redir", 32'(redirect), 32'd0);
        check("rst_tgt",   target,        32'd0);
        check_cnts("rst");
        #1 check("rst_stall", 32'(stall), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ack", 32'(br_ack), 32'd0);
            br_valid = 1'b0;
            rs_rdy = 1'($urandom); rt_rdy = 1'($urandom);
            #1 check("idle_stall", 32'(stall), 32'd0);
        end
    endtask

    // One branch transaction; fl >= 0 flushes in that cycle (must be <= need).
    task automatic run_br(input int t, input logic [31:0] pc, input logic [15:0] imm,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int drs, input int drt, input int fl);
        int    need, ackc, off;
        bit    tk, dropped;
        logic [31:0] tgt;
        need    = ref_need(t, drs, drt);
        ackc    = need + 1;
        dropped = (fl >= 0) && (fl <= need);
        tk      = ref_taken(t, rs, rt);
        off     = $signed(imm);
        tgt     = tk ? pc + 32'(4 + 4 * off) : 32'd0;
        for (int c = 0; c <= need + 2; c++) begin
            @(negedge clk);
            if (c > 0) check("ack", 32'(br_ack), 32'(!dropped && c == ackc));
            if (dropped && c == fl + 1) begin
                check_cnts("flush");
                flush = 1'b0; br_valid = 1'b0;
                return;
            end
            if (!dropped && c == ackc) begin
                if (m_br < MAXC) m_br++;
                if (tk && m_tk < MAXC) m_tk++;
                check("redirect", 32'(redirect), 32'(tk));
                check("target",   target,        tgt);
                check_cnts("ack");
                rs_val = $urandom; rt_val = $urandom;
                #1 check("stall_ack", 32'(stall), 32'd0);
            end else if (!dropped && c == ackc + 1) begin
                check("redir_post", 32'(redirect), 32'd0);
                check("tgt_post",   target,        32'd0);
                br_valid = 1'b0;
                return;
            end else begin
                flush    = (c == fl);
                br_valid = !flush;
                br_type  = 3'(t);
                pc_id    = pc;
                imm16    = imm;
                if (t <= 5) rs_rdy = (c >= drs); else rs_rdy = 1'($urandom);
                if (t <= 1) rt_rdy = (c >= drt); else rt_rdy = 1'($urandom);
                rs_val   = (t <= 5 && c >= drs) ? rs : $urandom;
                rt_val   = (t <= 1 && c >= drt) ? rt : $urandom;
                #1 check("stall", 32'(stall), 32'(br_valid));
            end
        end
    endtask

    initial begin
        int t, drs, drt, fl, need;
        logic [31:0] rs, rt;
        reset_n = 1'b0; flush = 1'b0; br_valid = 1'b0; br_type = '0;
        pc_id = '0; imm16 = '0; rs_val = '0; rt_val = '0; rs_rdy = 1'b0; rt_rdy = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed scenarios.
        run_br(0, 32'h0000_3000, 16'h0004, 32'd5, 32'd5, 0, 0, -1);
        idle_cycles(1);
        run_br(1, 32'h0000_3040, 16'h0010, 32'd7, 32'd7, 0, 3, -1);
        idle_cycles(1);
        run_br(5, 32'h0000_3100, 16'hFFFF, 32'h8000_0000, 32'd0, 0, 0, -1);
        run_br(2, 32'h0000_3100, 16'hFFFF, 32'h8000_0000, 32'd0, 0, 0, -1);
        run_br(0, 32'h0000_3200, 16'h0002, 32'd9, 32'd9, 0, 3, 2);
        run_br(0, 32'h0000_3200, 16'h0002, 32'd9, 32'd9, 0, 0, -1);
        run_br(6, 32'h0000_3300, 16'h0001, 32'd0, 32'd0, 2, 2, -1);

        // Reset while a branch waits for operands: dropped silently.
        @(negedge clk);
        br_valid = 1'b1; br_type = 3'd0; rs_rdy = 1'b1; rt_rdy = 1'b0;
        @(negedge clk);
        reset_n = 1'b0; rt_rdy = 1'b1;
        @(negedge clk);
        reset_n = 1'b1; br_valid = 1'b0;
        m_br = 0; m_tk = 0;
        check("wait_rst_ack", 32'(br_ack), 32'd0);
        check_cnts("wait_rst");
        run_br(4, 32'h0000_3400, 16'h8000, 32'd1, 32'd0, 1, 0, -1);

        // Randomized branches.
        for (int i = 0; i < 200; i++) begin
            t   = int'($urandom_range(0, 7));
            rs  = $urandom;
            case ($urandom_range(0, 3))
                0: rs = 32'd0;
                1: rs = 32'($signed($urandom_range(0, 4)) - 2);
                default: ;
            endcase
            rt  = ($urandom_range(0, 2) == 0) ? rs : $urandom;
            drs = int'($urandom_range(0, 3));
            drt = int'($urandom_range(0, 3));
            need = ref_need(t, drs, drt);
            fl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, need)) : -1;
            run_br(t, $urandom, 16'($urandom), rs, rt, drs, drt, fl);
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        // Drive counters into saturation with back-to-back taken branches.
        for (int i = 0; i < MAXC + 4; i++)
            run_br(0, $urandom, 16'($urandom), 32'd3, 32'd3, 0, 0, -1);
        check("sat_br_cnt",    32'(br_cnt),    32'(MAXC));
        check("sat_taken_cnt", 32'(taken_cnt), 32'(MAXC));

        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
